// File: rtl/nz_scan_ctrl.sv
// Turns a 64-bit sparse feature bitmap into beats of up to DIM set-bit positions,
// lowest index first, with backpressure, abort and one last beat per bitmap.
module nz_scan_ctrl #(
  parameter int SPAD_WIDTH = 64,
  parameter int DIM        = 4,
  parameter int ADDR_WIDTH = 6,
  parameter int BEAT_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      abort,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SPAD_WIDTH-1:0]     in_bitmap,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DIM*ADDR_WIDTH-1:0] out_addr,
  output logic [DIM-1:0]            out_mask,
  output logic                      out_last,
  output logic [BEAT_WIDTH-1:0]     out_beat,
  output logic                      busy
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t                    state, state_next;
  logic [SPAD_WIDTH-1:0]     work, work_next, work_cleared;
  logic [SPAD_WIDTH-1:0]     beat_src, beat_rest;
  logic [DIM*ADDR_WIDTH-1:0] beat_addr, addr_next;
  logic [DIM-1:0]            beat_mask, mask_next;
  logic                      beat_last, last_next;
  logic [BEAT_WIDTH-1:0]     beat_next;
  logic                      in_ready_next;
  int                        cnt;

  // Bits of `work` that remain once the beat currently on the outputs is taken.
  always_comb begin
    work_cleared = work;
    for (int l = 0; l < DIM; l++) begin
      if (out_mask[l]) work_cleared[out_addr[l*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
    end
  end

  assign beat_src = (state == IDLE) ? in_bitmap : work_cleared;

  always_comb begin
    beat_addr = '0;
    beat_mask = '0;
    beat_rest = beat_src;
    cnt       = 0;
    for (int i = 0; i < SPAD_WIDTH; i++) begin
      if (beat_src[i] && cnt < DIM) begin
        beat_addr[cnt*ADDR_WIDTH +: ADDR_WIDTH] = ADDR_WIDTH'(i);
        beat_mask[cnt] = 1'b1;
        beat_rest[i]   = 1'b0;
        cnt            = cnt + 1;
      end
    end
    beat_last = (beat_rest == '0);
  end

  always_comb begin
    state_next = state;
    work_next  = work;
    addr_next  = out_addr;
    mask_next  = out_mask;
    last_next  = out_last;
    beat_next  = out_beat;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          state_next = EMIT;
          work_next  = in_bitmap;
          addr_next  = beat_addr;
          mask_next  = beat_mask;
          last_next  = beat_last;
          beat_next  = '0;
        end
      end
      EMIT: begin
        if (out_ready) begin
          work_next = work_cleared;
          if (out_last) begin
            state_next = IDLE;
            beat_next  = '0;
          end else begin
            addr_next = beat_addr;
            mask_next = beat_mask;
            last_next = beat_last;
            beat_next = out_beat + BEAT_WIDTH'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
    // Abort outranks every handshake, including an accept in the same cycle.
    if (abort) begin
      state_next = IDLE;
      work_next  = '0;
      addr_next  = '0;
      mask_next  = '0;
      last_next  = 1'b0;
      beat_next  = '0;
    end
    in_ready_next = (state == IDLE) && (state_next == IDLE) && !abort;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      work     <= '0;
      in_ready <= 1'b0;
      out_addr <= '0;
      out_mask <= '0;
      out_last <= 1'b0;
      out_beat <= '0;
    end else begin
      state    <= state_next;
      work     <= work_next;
      in_ready <= in_ready_next;
      out_addr <= addr_next;
      out_mask <= mask_next;
      out_last <= last_next;
      out_beat <= beat_next;
    end
  end

  assign out_valid = (state == EMIT);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_nz_scan_ctrl.sv
// Directed self-checking bench for nz_scan_ctrl; each task drives one scenario
// and compares outputs against hand-computed beats.
module tb_nz_scan_ctrl;

  logic        clk;
  logic        reset_n;
  logic        abort;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_bitmap;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_addr;
  logic [3:0]  out_mask;
  logic        out_last;
  logic [3:0]  out_beat;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  nz_scan_ctrl dut (
    .clk(clk), .reset_n(reset_n), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_bitmap(in_bitmap),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_mask(out_mask), .out_last(out_last), .out_beat(out_beat), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for in_ready, then offers the bitmap for one edge.
  task automatic send(input logic [63:0] bm);
    int n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (!in_ready) begin
      failures++;
      $display("FAIL send_wait: in_ready=%0b required 1", in_ready);
    end
    in_valid  = 1'b1;
    in_bitmap = bm;
    tick();
    in_valid  = 1'b0;
    in_bitmap = '0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; abort = 1'b0; in_valid = 1'b0; in_bitmap = '0; out_ready = 1'b1;
    #2;
    checks++;
    if ({in_ready, out_valid, out_addr, out_mask, out_last, out_beat, busy} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got rdy=%0b v=%0b a=%h m=%h l=%0b b=%0d busy=%0b required all 0",
               in_ready, out_valid, out_addr, out_mask, out_last, out_beat, busy);
    end
    tick(); tick();
    reset_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready_before_edge: in_ready=%0b required 0", in_ready);
    end
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready_after_edge: in_ready=%0b required 1", in_ready);
    end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    send(64'h8421);
    checks++;
    if ({out_valid, out_addr, out_mask, out_last, out_beat, busy} !==
        {1'b1, 6'd15, 6'd10, 6'd5, 6'd0, 4'b1111, 1'b1, 4'd0, 1'b1}) begin
      failures++;
      $display("FAIL single_beat: v=%0b a=%h m=%b l=%0b b=%0d busy=%0b required v=1 a=%h m=1111 l=1 b=0 busy=1",
               out_valid, out_addr, out_mask, out_last, out_beat, busy,
               {6'd15, 6'd10, 6'd5, 6'd0});
    end
    tick();
    checks++;
    if ({out_valid, busy, in_ready} !== 3'b000) begin
      failures++;
      $display("FAIL single_after_last: v=%0b busy=%0b rdy=%0b required 000", out_valid, busy, in_ready);
    end
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL single_ready_return: in_ready=%0b required 1", in_ready);
    end
  endtask

  task automatic test_full();
    logic [23:0] exp;
    out_ready = 1'b1;
    send(64'hFFFF_FFFF_FFFF_FFFF);
    for (int k = 0; k < 16; k++) begin
      exp = {6'(4*k+3), 6'(4*k+2), 6'(4*k+1), 6'(4*k)};
      checks++;
      if ({out_valid, out_addr, out_mask, out_last, out_beat} !==
          {1'b1, exp, 4'b1111, (k == 15), 4'(k)}) begin
        failures++;
        $display("FAIL full_beat%0d: v=%0b a=%h m=%b l=%0b b=%0d required v=1 a=%h m=1111 l=%0b b=%0d",
                 k, out_valid, out_addr, out_mask, out_last, out_beat, exp, (k == 15), k);
      end
      tick();
    end
    checks++;
    if ({out_valid, busy, in_ready} !== 3'b000) begin
      failures++;
      $display("FAIL full_after_last: v=%0b busy=%0b rdy=%0b required 000", out_valid, busy, in_ready);
    end
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL full_ready_return: in_ready=%0b required 1", in_ready);
    end
  endtask

  task automatic test_zero_and_sparse();
    out_ready = 1'b1;
    send(64'h0);
    checks++;
    if ({out_valid, out_addr, out_mask, out_last, out_beat} !== {1'b1, 24'h0, 4'b0000, 1'b1, 4'd0}) begin
      failures++;
      $display("FAIL zero_beat: v=%0b a=%h m=%b l=%0b b=%0d required v=1 a=0 m=0000 l=1 b=0",
               out_valid, out_addr, out_mask, out_last, out_beat);
    end
    tick();
    send(64'hC000_0000_0000_0002);
    checks++;
    if ({out_valid, out_addr, out_mask, out_last, out_beat} !==
        {1'b1, 6'd0, 6'd63, 6'd62, 6'd1, 4'b0111, 1'b1, 4'd0}) begin
      failures++;
      $display("FAIL sparse_beat: v=%0b a=%h m=%b l=%0b b=%0d required v=1 a=%h m=0111 l=1 b=0",
               out_valid, out_addr, out_mask, out_last, out_beat, {6'd0, 6'd63, 6'd62, 6'd1});
    end
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b1;
    send(64'h0000_0000_00FF_00FF);
    checks++;
    if ({out_addr, out_beat, out_last} !== {6'd3, 6'd2, 6'd1, 6'd0, 4'd0, 1'b0}) begin
      failures++;
      $display("FAIL bp_beat0: a=%h b=%0d l=%0b required a=%h b=0 l=0",
               out_addr, out_beat, out_last, {6'd3, 6'd2, 6'd1, 6'd0});
    end
    tick();
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if ({out_valid, out_addr, out_mask, out_beat, out_last} !==
          {1'b1, 6'd7, 6'd6, 6'd5, 6'd4, 4'b1111, 4'd1, 1'b0}) begin
        failures++;
        $display("FAIL bp_hold%0d: v=%0b a=%h m=%b b=%0d l=%0b required v=1 a=%h m=1111 b=1 l=0",
                 c, out_valid, out_addr, out_mask, out_beat, out_last, {6'd7, 6'd6, 6'd5, 6'd4});
      end
      if (c < 3) tick();
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if ({out_valid, out_addr, out_beat, out_last} !== {1'b1, 6'd19, 6'd18, 6'd17, 6'd16, 4'd2, 1'b0}) begin
      failures++;
      $display("FAIL bp_beat2: v=%0b a=%h b=%0d l=%0b required a=%h b=2 l=0",
               out_valid, out_addr, out_beat, out_last, {6'd19, 6'd18, 6'd17, 6'd16});
    end
    tick();
    checks++;
    if ({out_valid, out_addr, out_beat, out_last} !== {1'b1, 6'd23, 6'd22, 6'd21, 6'd20, 4'd3, 1'b1}) begin
      failures++;
      $display("FAIL bp_beat3: v=%0b a=%h b=%0d l=%0b required a=%h b=3 l=1",
               out_valid, out_addr, out_beat, out_last, {6'd23, 6'd22, 6'd21, 6'd20});
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_done: out_valid=%0b required 0", out_valid);
    end
  endtask

  task automatic test_abort();
    out_ready = 1'b1;
    send(64'hFFFF_FFFF_FFFF_FFFF);
    tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if ({out_valid, out_beat, busy, in_ready} !== {1'b0, 4'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL abort_flush: v=%0b b=%0d busy=%0b rdy=%0b required 0 0 0 0",
               out_valid, out_beat, busy, in_ready);
    end
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL abort_ready: in_ready=%0b required 1", in_ready);
    end
    // Abort coinciding with an offered bitmap must win over the accept.
    in_valid = 1'b1; in_bitmap = 64'hF0; abort = 1'b1;
    tick();
    in_valid = 1'b0; in_bitmap = '0; abort = 1'b0;
    checks++;
    if ({out_valid, busy} !== 2'b00) begin
      failures++;
      $display("FAIL abort_vs_accept: v=%0b busy=%0b required 00", out_valid, busy);
    end
    send(64'h1);
    checks++;
    if ({out_valid, out_addr, out_mask, out_beat, out_last} !== {1'b1, 24'h0, 4'b0001, 4'd0, 1'b1}) begin
      failures++;
      $display("FAIL abort_next: v=%0b a=%h m=%b b=%0d l=%0b required v=1 a=0 m=0001 b=0 l=1",
               out_valid, out_addr, out_mask, out_beat, out_last);
    end
    tick();
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b1;
    send(64'hFFFF_FFFF_FFFF_FFFF);
    tick(); tick();
    reset_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, out_addr, out_mask, out_last, out_beat, busy} !== '0) begin
      failures++;
      $display("FAIL midreset_outputs: rdy=%0b v=%0b a=%h m=%h l=%0b b=%0d busy=%0b required all 0",
               in_ready, out_valid, out_addr, out_mask, out_last, out_beat, busy);
    end
    tick();
    reset_n = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid} !== 2'b00) begin
      failures++;
      $display("FAIL midreset_release: rdy=%0b v=%0b required 00", in_ready, out_valid);
    end
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL midreset_ready: in_ready=%0b required 1", in_ready);
    end
    send(64'hFF);
    checks++;
    if ({out_valid, out_addr, out_beat, out_last} !== {1'b1, 6'd3, 6'd2, 6'd1, 6'd0, 4'd0, 1'b0}) begin
      failures++;
      $display("FAIL midreset_beat0: v=%0b a=%h b=%0d l=%0b required a=%h b=0 l=0",
               out_valid, out_addr, out_beat, out_last, {6'd3, 6'd2, 6'd1, 6'd0});
    end
    tick();
    checks++;
    if ({out_valid, out_addr, out_beat, out_last} !== {1'b1, 6'd7, 6'd6, 6'd5, 6'd4, 4'd1, 1'b1}) begin
      failures++;
      $display("FAIL midreset_beat1: v=%0b a=%h b=%0d l=%0b required a=%h b=1 l=1",
               out_valid, out_addr, out_beat, out_last, {6'd7, 6'd6, 6'd5, 6'd4});
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_zero_and_sparse();
    test_backpressure();
    test_abort();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nz_scan_ctrl.md
# nz_scan_ctrl

Sequencing controller for the nonzero-address generation stage of the feature path. It accepts one 64-bit sparse feature bitmap per transaction and emits the positions of its set bits as a stream of beats. Each beat carries up to DIM addresses, lowest index first, and feeds the DIM PEs of one array row. It replaces single-shot nonzero extraction with a multi-beat walk that tolerates backpressure, so bitmaps with more than DIM nonzeros are fully drained.

## Interface
- SPAD_WIDTH, 64: bitmap width, i.e. the spad k-subvector length.
- DIM, 4: addresses per beat, i.e. PEs per row.
- ADDR_WIDTH, 6: log2(SPAD_WIDTH).
- BEAT_WIDTH, 4: log2(SPAD_WIDTH/DIM); sized to count beats.
- clk  in  1  clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- abort  in  1  synchronous flush; drops the current bitmap.
- in_valid  in  1  a bitmap is offered.
- in_ready  out  1  controller can accept a bitmap.
- in_bitmap  in  SPAD_WIDTH  feature bitmap; bit i set means element i is nonzero.
- out_valid  out  1  a beat is presented.
- out_ready  in  1  downstream accepts the beat.
- out_addr  out  DIM*ADDR_WIDTH  lane i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- out_mask  out  DIM  bit i set means lane i holds a valid address.
- out_last  out  1  final beat of the current bitmap.
- out_beat  out  BEAT_WIDTH  index of this beat within the bitmap, starting at 0.
- busy  out  1  a bitmap is in progress (state is not IDLE).

## Operation
- States are IDLE and EMIT. The working register `work` holds the SPAD_WIDTH bits not yet emitted.
- IDLE: in_ready=1. On in_valid&&in_ready, load `work`, compute the first beat from in_bitmap, register it onto the out_* outputs, and go to EMIT.
- Beat computation is combinational from the source bitmap:
  - Lane 0 gets the lowest set bit, lane 1 the next-lowest, and so on up to DIM lanes.
  - Unfilled lanes get out_mask bit 0 and out_addr lane 0.
  - out_last=1 when no set bits remain after this beat's bits are removed.
- EMIT: out_valid=1.
  - On out_ready, clear the emitted bits from `work`.
  - If out_last, go to IDLE.
  - Otherwise register the next beat from the updated `work` in the same cycle and increment out_beat. Back-to-back beats run at one per cycle.
- An all-zero bitmap produces exactly one beat: out_mask=0, out_last=1, out_beat=0. Downstream always sees one last per bitmap.
- While out_valid=1 and out_ready=0, out_addr, out_mask, out_last and out_beat are held stable.
- abort is sampled every cycle. It forces IDLE, clears `work`, sets out_valid=0 and out_beat=0, and drops any in-flight beat. abort has priority over all handshakes, including a same-cycle accept.
- A full bitmap produces at most SPAD_WIDTH/DIM = 16 beats, so out_beat never wraps.

## Timing
- Reset (reset_n low) takes effect immediately:
  - state=IDLE, work=0.
  - in_ready=0, out_valid=0, out_addr=0, out_mask=0, out_last=0, out_beat=0, busy=0.
- in_ready is a registered output. It rises on the first clk edge after reset_n deasserts, then equals (state==IDLE && !abort-flush).
- Latency: a bitmap accepted at edge N has its first beat valid after edge N (visible in cycle N+1).
- Throughput is one beat per cycle with out_ready held high.
- A bitmap producing B beats occupies the controller for B cycles plus one IDLE cycle. No new bitmap is accepted in the cycle of the last-beat handshake.
- busy=1 from the accept edge through the last-beat handshake edge.
- reset_n asserted mid-stream aborts the transaction with no further beats. After release, the next bitmap starts at out_beat=0.

## Test plan
- in_bitmap=64'h8421, out_ready=1 -> one beat: addr lanes {0,5,10,15}, mask 4'b1111, last=1, beat=0. First beat is valid one cycle after accept.
- in_bitmap=64'hFFFF_FFFF_FFFF_FFFF, out_ready=1 -> 16 consecutive beats. Beat k carries lanes {4k,4k+1,4k+2,4k+3}, last only on beat 15. busy drops afterwards and in_ready returns one cycle later.
- in_bitmap=64'h0 -> one beat with mask 4'b0000 and last=1. in_bitmap=64'hC000_0000_0000_0002 -> one beat with lanes {1,62,63}, mask 4'b0111, last=1.
- in_bitmap=64'h0000_0000_00FF_00FF with out_ready low for 3 cycles at beat 1 -> beat 1 (lanes {4,5,6,7}) held stable. Remaining beats resume as beat 2 {16,17,18,19} and beat 3 {20,21,22,23}, last on beat 3; none lost or duplicated.
- abort at beat 2 of an all-ones bitmap -> out_valid=0 next cycle, then in_ready=1. A following bitmap 64'h1 gives one beat: lane 0=0, mask 4'b0001, beat=0, last=1.
- reset_n pulsed low mid-stream -> all outputs 0 immediately. in_ready rises one edge after release, and a new bitmap streams correctly from beat 0.
